// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pkg
//  Description : Shared widths, reset PC and FSM state encoding for the
//                NPC instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    localparam int          IFU_PC_W     = 64;
    localparam int          IFU_INST_W   = 32;
    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

    // Fetch FSM encoding, kept as plain 2-bit constants so netlists and
    // waveform decoders from older flows read the same values.
    localparam logic [1:0]  ST_REQ    = 2'd0;
    localparam logic [1:0]  ST_WAIT   = 2'd1;
    localparam logic [1:0]  ST_HOLD   = 2'd2;
    localparam logic [1:0]  ST_HALTED = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_if
//  Description : Bundle of the fetch unit's memory, redirect and decoder-side
//                handshake signals. master = fetch unit, slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ifu_if #(
    parameter int PC_W   = ifu_pkg::IFU_PC_W,
    parameter int INST_W = ifu_pkg::IFU_INST_W
) ();

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, halt, out_ready
    );

endinterface
`default_nettype wire

// File: rtl/ifu_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pc_reg
//  Description : Architectural PC register. Priority: reset, redirect load,
//                sequential +4 advance. Arithmetic wraps modulo 2^PC_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter int              PC_W     = IFU_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            load,
    input  wire logic [PC_W-1:0] load_pc,
    input  wire logic            advance,
    output logic      [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;

    // Next-PC select: a redirect always beats the sequential advance.
    always_comb begin
        w_pc_next = r_pc;
        if (load) begin
            w_pc_next = load_pc;
        end else if (advance) begin
            w_pc_next = r_pc + PC_STEP;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ifu
//  Description : Instruction fetch unit. One outstanding request to imem,
//                returned instruction held under valid/ready to decode,
//                control-flow redirects, terminal halt on ebreak.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter int              PC_W     = IFU_PC_W,
    parameter int              INST_W   = IFU_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(IFU_RESET_PC)
) (
    input  wire logic clk,
    input  wire logic rst,
    ifu_if.master     bus
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_drop;
    logic              w_drop_next;
    logic              r_out_valid;
    logic [INST_W-1:0] r_out_inst;
    logic [PC_W-1:0]   r_out_pc;
    logic [PC_W-1:0]   w_pc;
    logic              w_pc_load;
    logic              w_pc_adv;
    logic              w_capture;

    ifu_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (w_pc_load),
        .load_pc  (bus.redirect_pc),
        .advance  (w_pc_adv),
        .pc       (w_pc)
    );

    // Fetch FSM next-state, drop flag and PC control. Halt overrides all.
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        w_pc_load    = 1'b0;
        w_pc_adv     = 1'b0;
        w_capture    = 1'b0;
        if (bus.halt) begin
            w_state_next = ST_HALTED;
            w_drop_next  = 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    w_pc_load = bus.redirect_valid;
                    if (bus.imem_req_ready) begin
                        w_state_next = ST_WAIT;
                        // The accepted address is the pre-redirect PC, so its
                        // response is already stale.
                        w_drop_next  = bus.redirect_valid;
                    end
                end
                ST_WAIT: begin
                    w_pc_load = bus.redirect_valid;
                    if (bus.imem_resp_valid) begin
                        w_drop_next = 1'b0;
                        if (r_drop || bus.redirect_valid) begin
                            w_state_next = ST_REQ;
                        end else begin
                            w_state_next = ST_HOLD;
                            w_capture    = 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        w_drop_next = 1'b1;
                    end
                end
                ST_HOLD: begin
                    w_pc_load = bus.redirect_valid;
                    w_pc_adv  = bus.out_ready && !bus.redirect_valid;
                    if (bus.redirect_valid || bus.out_ready) begin
                        w_state_next = ST_REQ;
                    end
                end
                default: begin
                    // ST_HALTED: terminal until reset.
                end
            endcase
        end
    end

    // FSM state and drop flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_REQ;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
        end
    end

    // Registered decoder-side outputs; payload only changes on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= RESET_PC;
        end else begin
            r_out_valid <= (w_state_next == ST_HOLD);
            if (w_capture) begin
                r_out_inst <= bus.imem_resp_data;
                r_out_pc   <= w_pc;
            end
        end
    end

    assign bus.imem_req_valid = (r_state == ST_REQ) && !rst;
    assign bus.imem_req_addr  = w_pc;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_inst       = r_out_inst;
    assign bus.out_pc         = r_out_pc;

    // A response is only legal while waiting; after halt, late ones are benign.
    a_resp_only_in_wait : assert property (
        @(posedge clk) disable iff (rst)
        bus.imem_resp_valid |-> (r_state == ST_WAIT || r_state == ST_HALTED)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu
//  Description : Self-checking bench for ifu: randomized memory latency,
//                backpressure, redirects and halt against a transaction
//                level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ifu_if bus ();

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_deliv = 0;

    // Reference model: next address the fetch stream must request, whether a
    // request is outstanding (and stale), and what instruction is on offer.
    logic [63:0] m_pc;
    bit          m_inflight;
    bit          m_stale;
    bit          m_hold;
    bit          m_halted;
    logic [63:0] m_out_pc;
    logic [31:0] m_out_inst;
    logic [63:0] mem_addr;
    int          lat_left;

    int p_ready, p_oready, p_redir, max_lat;
    bit halt_arm;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h1357_2468;
    endfunction

    function automatic logic [63:0] pick_target();
        if ($urandom_range(0, 7) == 0)
            return ($urandom_range(0, 1) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'hFFFF_FFFF_FFFF_FFFC;
        return RST_PC + 64'({$urandom_range(0, 1023), 2'b00});
    endfunction

    task automatic drive_inputs();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom;
        if (m_inflight) begin
            lat_left--;
            if (lat_left == 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem(mem_addr);
            end
        end
        bus.imem_req_ready = ($urandom_range(0, 99) < p_ready);
        bus.out_ready      = ($urandom_range(0, 99) < p_oready);
        bus.redirect_valid = ($urandom_range(0, 99) < p_redir);
        bus.redirect_pc    = pick_target();
        bus.halt           = 1'b0;
        if (halt_arm && m_inflight && !bus.imem_resp_valid && !m_halted) begin
            bus.halt = 1'b1;
            halt_arm = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs applied this cycle.
    task automatic update_model(input bit exp_req);
        if (m_halted || bus.halt) begin
            if (bus.imem_resp_valid) m_inflight = 1'b0;
            m_halted = 1'b1;
            m_hold   = 1'b0;
        end else if (exp_req) begin
            if (bus.imem_req_ready) begin
                m_inflight = 1'b1;
                m_stale    = bus.redirect_valid;
                mem_addr   = bus.imem_req_addr;
                lat_left   = $urandom_range(1, max_lat);
            end
            if (bus.redirect_valid) m_pc = bus.redirect_pc;
        end else if (m_inflight) begin
            if (bus.imem_resp_valid) begin
                m_inflight = 1'b0;
                if (!m_stale && !bus.redirect_valid) begin
                    m_hold     = 1'b1;
                    m_out_pc   = m_pc;
                    m_out_inst = mem(m_pc);
                end
                if (bus.redirect_valid) m_pc = bus.redirect_pc;
            end else if (bus.redirect_valid) begin
                m_pc    = bus.redirect_pc;
                m_stale = 1'b1;
            end
        end else if (m_hold) begin
            if (bus.redirect_valid) begin
                m_pc   = bus.redirect_pc;
                m_hold = 1'b0;
            end else if (bus.out_ready) begin
                m_pc   = m_pc + 64'd4;
                m_hold = 1'b0;
                n_deliv++;
            end
        end
    endtask

    task automatic step();
        bit exp_req;
        @(negedge clk);
        exp_req = !m_inflight && !m_hold && !m_halted;
        chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
        if (exp_req) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
        if (m_hold) begin
            chk("out_pc", bus.out_pc, m_out_pc);
            chk("out_inst", 64'(bus.out_inst), 64'(m_out_inst));
        end
        update_model(exp_req);
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.halt            = 1'b0;
        bus.out_ready       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_inst", 64'(bus.out_inst), 64'd0);
        chk("rst_out_pc", bus.out_pc, RST_PC);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        m_pc       = RST_PC;
        m_inflight = 1'b0;
        m_stale    = 1'b0;
        m_hold     = 1'b0;
        m_halted   = 1'b0;
        lat_left   = 0;
        halt_arm   = 1'b0;
        n_deliv    = 0;
        drive_inputs();
    endtask

    task automatic set_knobs(input int rdy, input int ordy, input int redir, input int lat);
        p_ready  = rdy;
        p_oready = ordy;
        p_redir  = redir;
        max_lat  = lat;
    endtask

    initial begin
        set_knobs(100, 100, 0, 1);
        halt_arm = 1'b0;
        do_reset();

        // Straight-line fetch: one instruction every three cycles.
        repeat (30) step();
        chk("straight_line_deliveries", 64'(n_deliv), 64'd10);

        // Heavy decoder backpressure.
        set_knobs(100, 15, 0, 1);
        repeat (80) step();

        // Fully random traffic with redirects in every state.
        set_knobs(60, 60, 10, 3);
        repeat (2000) step();
        chk("random_made_progress", 64'(n_deliv > 50), 64'd1);

        // Halt while a response is outstanding; late response must vanish.
        set_knobs(60, 60, 10, 3);
        halt_arm = 1'b1;
        repeat (60) step();
        chk("halt_reached", 64'(m_halted), 64'd1);

        // Restart from reset PC after halt.
        set_knobs(100, 100, 0, 1);
        do_reset();
        repeat (9) step();
        chk("restart_deliveries", 64'(n_deliv), 64'd3);

        set_knobs(70, 50, 15, 3);
        repeat (1500) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit for the NPC core. It sits directly upstream of the instruction decoder and owns the architectural PC. It issues one-outstanding fetch requests to instruction memory, holds the returned 32-bit instruction stable under a valid/ready handshake until the decoder side accepts it, and applies PC redirects from jal/jalr/branch resolution. It stops fetching permanently on halt (ebreak).

## Interface
Parameters:
- RESET_PC, 64'h8000_0000, PC loaded on reset.
- PC_W, 64, PC/address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  PC_W  fetch address; always equals the current PC.
- imem_resp_valid  in  1  response valid. Single-cycle pulse; the block always accepts it.
- imem_resp_data  in  INST_W  fetched instruction.
- redirect_valid  in  1  control-flow redirect.
- redirect_pc  in  PC_W  redirect target, used as-is. Alignment checks belong to execute.
- halt  in  1  stop fetching (ebreak retired).
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  downstream consumes the instruction.
- out_inst  out  INST_W  instruction to decoder.
- out_pc  out  PC_W  PC of out_inst.

## Operation
- State machine states:
  - REQ: drive req_valid.
  - WAIT: request accepted, response pending.
  - HOLD: out_valid=1.
  - HALTED: terminal until rst.
- A single `drop` flag marks an in-flight response as stale.
- REQ:
  - imem_req_valid=1, addr=pc.
  - req_ready → WAIT.
  - redirect with no req_ready → pc←redirect_pc, stay REQ.
  - redirect together with req_ready → pc←redirect_pc, WAIT, drop←1.
- WAIT:
  - resp_valid with drop=0 → out_inst←resp_data, out_pc←pc, HOLD.
  - resp_valid with drop=1 → discard data, drop←0, REQ.
  - redirect without resp_valid → pc←redirect_pc, drop←1.
  - redirect with resp_valid → discard data, pc←redirect_pc, drop←0, REQ.
- HOLD:
  - out_valid=1. out_inst and out_pc stay stable until the handshake.
  - out_ready → pc←pc+4, REQ.
  - redirect → pc←redirect_pc, REQ. out_valid falls next cycle. Redirect beats out_ready in the same cycle, and pc+4 is not applied.
- Halt: highest priority in any state. Next state is HALTED, with req_valid=0 and out_valid=0. Late responses and redirects are ignored.
- imem_resp_valid outside WAIT is a protocol violation: ignore it and fire a simulation assertion.
- PC arithmetic is modulo 2^PC_W; pc+4 wraps silently.

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC, drop=0.
  - imem_req_valid=0 while rst=1; it rises in the first cycle after rst deasserts.
  - imem_req_addr=RESET_PC.
  - out_valid=0, out_inst=0, out_pc=RESET_PC.
- Reset mid-operation discards any outstanding request or held instruction. A response arriving after reset is dropped, because the state is not WAIT.
- Latency:
  - Request acceptance at cycle t → earliest resp at t+1.
  - Resp at cycle r → out_valid at r+1.
  - Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD); no prefetch.
- Outputs are all registered except imem_req_valid and imem_req_addr, which are decoded from state and pc.
- Redirect takes effect on the next fetch address in the following cycle.

## Structure
- RESET_PC, INST_W, PC_W and the state encoding (2-bit: REQ=0, WAIT=1, HOLD=2, HALTED=3) go in include/defines.v beside the existing width macros.
- Natural sub-module: ifu_pc_reg. It holds the PC register with reset, redirect and +4 advance, plus its priority mux.
- The FSM, drop flag and output buffer stay in ifu.

## Test plan
- Reset then straight-line fetch, memory with 1-cycle latency and out_ready=1:
  - addresses 0x8000_0000, 0x8000_0004, 0x8000_0008;
  - out_inst matches memory, with one instruction every 3 cycles.
- Backpressure, out_ready=0 for 5 cycles in HOLD:
  - out_inst and out_pc stay stable;
  - no new request is issued;
  - next address is +4 after the ready pulse.
- Redirect during WAIT (target 0x8000_0100), response for the old PC arrives 2 cycles later:
  - the old response is never presented;
  - the next request is 0x8000_0100;
  - out_pc is 0x8000_0100.
- Redirect together with out_ready in HOLD:
  - next request address is redirect_pc, not pc+4.
- Redirect in the same cycle as req_ready:
  - the response is dropped and a refetch from the target follows.
- halt asserted in WAIT, then a response arrives:
  - out_valid stays 0 and no further requests are issued.
  - After a rst pulse, the next fetch is at 0x8000_0000.
